// File: rtl/eth_payload_rx.sv
// Ethernet receive payload stage: strips the 4-byte FCS, bounds length frames, and flags bad TL, runt, oversize and abort.
// Latency: 5 cycles from byte in to payload out. No backpressure. ETH_PAYLOAD_PAD_STRIP_EN drops LEN-mode pad bytes.
module eth_payload_rx #(
  parameter int MAX_LEN = 1500,
  parameter int MIN_LEN = 46
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  data,
  input  logic        start,
  output logic [7:0]  payload_data,
  output logic        payload_valid,
  output logic        payload_last,
  output logic        frame_done,
  output logic        frame_error,
  output logic        ethertype_mode,
  output logic [10:0] byte_count
);

  localparam logic [1:0]  ST_IDLE     = 2'd0;
  localparam logic [1:0]  ST_LEN      = 2'd1;
  localparam logic [1:0]  ST_STREAM   = 2'd2;
  localparam logic [15:0] LP_MAX      = 16'(MAX_LEN);
  localparam logic [15:0] LP_MAX_E    = 16'(MAX_LEN + 4);
  localparam logic [15:0] LP_MIN      = 16'(MIN_LEN);
  localparam logic [15:0] LP_MIN_E    = 16'(MIN_LEN + 4);
  localparam logic [15:0] LP_TYPE_MIN = 16'h0600;

  logic [1:0]  r_state;
  logic [15:0] r_hist;
  logic [7:0]  r_dl [4];
  logic [15:0] r_elen;
  logic [15:0] r_rx_cnt;
  logic [7:0]  r_pdat;
  logic        r_pvld;
  logic        r_plast;
  logic        r_done;
  logic        r_err;
  logic        r_etype;
  logic [10:0] r_bcnt;
`ifdef ETH_PAYLOAD_PAD_STRIP_EN
  logic [15:0] r_tl;
`endif

  logic        w_accept;
  logic [15:0] w_rx_next;
  logic [15:0] w_idx;
  logic        w_full;
  logic        w_keep;
  logic        w_last_hit;

  // A start coinciding with frame_done belongs to a block that has not yet settled in IDLE.
  assign w_accept  = start && enable && (r_state == ST_IDLE) && !r_done;
  assign w_rx_next = r_rx_cnt + 16'd1;
  assign w_idx     = r_rx_cnt - 16'd4;
  assign w_full    = (r_rx_cnt >= 16'd4);

`ifdef ETH_PAYLOAD_PAD_STRIP_EN
  assign w_keep     = (w_idx < r_tl);
  assign w_last_hit = (r_tl != 16'd0) && (w_idx == r_tl - 16'd1);
`else
  assign w_keep     = 1'b1;
  assign w_last_hit = (w_idx == r_elen - 16'd1);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_hist   <= '0;
      for (int i = 0; i < 4; i++) r_dl[i] <= '0;
      r_elen   <= '0;
      r_rx_cnt <= '0;
      r_pdat   <= '0;
      r_pvld   <= 1'b0;
      r_plast  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_etype  <= 1'b0;
      r_bcnt   <= '0;
`ifdef ETH_PAYLOAD_PAD_STRIP_EN
      r_tl     <= '0;
`endif
    end else begin
      r_pvld  <= 1'b0;
      r_plast <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      if (enable) r_hist <= {r_hist[7:0], data};

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rx_cnt <= 16'd1;
            r_dl[0]  <= data;
            r_bcnt   <= '0;
            r_elen   <= (r_hist > LP_MIN) ? r_hist : LP_MIN;
`ifdef ETH_PAYLOAD_PAD_STRIP_EN
            r_tl     <= r_hist;
`endif
            if (r_hist <= LP_MAX) begin
              r_state <= ST_LEN;
              r_etype <= 1'b0;
            end else if (r_hist >= LP_TYPE_MIN) begin
              r_state <= ST_STREAM;
              r_etype <= 1'b1;
            end else begin
              r_etype <= 1'b0;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end

        ST_LEN: begin
          if (!enable) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_dl[0]  <= data;
            r_dl[1]  <= r_dl[0];
            r_dl[2]  <= r_dl[1];
            r_dl[3]  <= r_dl[2];
            r_rx_cnt <= w_rx_next;
            if (w_full && w_keep) begin
              r_pdat  <= r_dl[3];
              r_pvld  <= 1'b1;
              r_plast <= w_last_hit;
              r_bcnt  <= r_bcnt + 11'd1;
            end
            // The four bytes still queued at this point are the FCS and are never emitted.
            if (w_rx_next == r_elen + 16'd4) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end

        ST_STREAM: begin
          if (!enable) begin
            r_done  <= 1'b1;
            r_err   <= (r_rx_cnt < LP_MIN_E);
            r_state <= ST_IDLE;
          end else if (w_rx_next > LP_MAX_E) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_dl[0]  <= data;
            r_dl[1]  <= r_dl[0];
            r_dl[2]  <= r_dl[1];
            r_dl[3]  <= r_dl[2];
            r_rx_cnt <= w_rx_next;
            if (w_full) begin
              r_pdat <= r_dl[3];
              r_pvld <= 1'b1;
              r_bcnt <= r_bcnt + 11'd1;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign payload_data   = r_pdat;
  assign payload_valid  = r_pvld;
  assign payload_last   = r_plast;
  assign frame_done     = r_done;
  assign frame_error    = r_err;
  assign ethertype_mode = r_etype;
  assign byte_count     = r_bcnt;

endmodule

// File: tb/tb_eth_payload_rx.sv
// Directed bench for eth_payload_rx: table of frame descriptors plus hand-written reset and same-cycle sequences.
module tb_eth_payload_rx;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  data;
  logic        start;
  logic [7:0]  payload_data;
  logic        payload_valid;
  logic        payload_last;
  logic        frame_done;
  logic        frame_error;
  logic        ethertype_mode;
  logic [10:0] byte_count;

  int n_cmp = 0;
  int n_bad = 0;

  eth_payload_rx dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .data           (data),
    .start          (start),
    .payload_data   (payload_data),
    .payload_valid  (payload_valid),
    .payload_last   (payload_last),
    .frame_done     (frame_done),
    .frame_error    (frame_error),
    .ethertype_mode (ethertype_mode),
    .byte_count     (byte_count)
  );

  always #5 clock = ~clock;

  // Cycle offsets are relative to the start cycle S; -1 means "never".
  typedef struct {
    logic [15:0] tl;
    int          nbytes;
    int          seed;
    int          exp_valid;
    int          exp_first;
    int          exp_done;
    int          exp_err;
    int          exp_last;
    int          exp_bc;
    int          exp_etype;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic [7:0] d, input logic st);
    @(posedge clock);
    #1;
    enable = en;
    data   = d;
    start  = st;
  endtask

  task automatic run_frame(input vec_t v, input int id);
    int vcnt = 0, first = -1, done_cnt = 0, done_cyc = -1, err_cnt = 0;
    int last_cnt = 0, last_cyc = -1, bc = -1, et = -1, derr = 0;
    step(1'b1, v.tl[15:8], 1'b0);
    step(1'b1, v.tl[7:0], 1'b0);
    for (int k = 0; k < v.nbytes + 8; k++) begin
      if (k < v.nbytes) step(1'b1, 8'(v.seed + k), k == 0);
      else              step(1'b0, 8'h00, 1'b0);
      if (payload_valid) begin
        if (first < 0) first = k;
        if (payload_data !== 8'(v.seed + vcnt)) derr++;
        vcnt++;
      end
      if (payload_last) begin
        last_cnt++;
        last_cyc = k;
      end
      if (frame_error) err_cnt++;
      if (frame_done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = k;
          bc = int'(byte_count);
          et = int'(ethertype_mode);
        end
      end
    end
    chk($sformatf("v%0d_valid_cnt", id), vcnt, v.exp_valid);
    chk($sformatf("v%0d_first_valid", id), first, v.exp_first);
    chk($sformatf("v%0d_data_errs", id), derr, 0);
    chk($sformatf("v%0d_done_cnt", id), done_cnt, 1);
    chk($sformatf("v%0d_done_cyc", id), done_cyc, v.exp_done);
    chk($sformatf("v%0d_err_cnt", id), err_cnt, v.exp_err);
    chk($sformatf("v%0d_last_cnt", id), last_cnt, (v.exp_last >= 0) ? 1 : 0);
    if (v.exp_last >= 0) chk($sformatf("v%0d_last_cyc", id), last_cyc, v.exp_last);
    chk($sformatf("v%0d_byte_count", id), bc, v.exp_bc);
    chk($sformatf("v%0d_etype", id), et, v.exp_etype);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_data"},  int'(payload_data), 0);
    chk({pfx, "_valid"}, int'(payload_valid), 0);
    chk({pfx, "_last"},  int'(payload_last), 0);
    chk({pfx, "_done"},  int'(frame_done), 0);
    chk({pfx, "_err"},   int'(frame_error), 0);
    chk({pfx, "_etype"}, int'(ethertype_mode), 0);
    chk({pfx, "_bc"},    int'(byte_count), 0);
  endtask

  initial begin
    int dn, pv;
    //              tl        n     seed   valid first done err last  bc    etype
    vecs[0] = '{16'h0040,   68,    0,    64,   5,   68,  0,  68,   64,   0};
`ifdef ETH_PAYLOAD_PAD_STRIP_EN
    vecs[1] = '{16'h0010,   50, 8'h80,   16,   5,   50,  0,  20,   16,   0};
`else
    vecs[1] = '{16'h0010,   50, 8'h80,   46,   5,   50,  0,  50,   46,   0};
`endif
    vecs[2] = '{16'h0800,  100, 8'h10,   96,   5,  101,  0,  -1,   96,   1};
    vecs[3] = '{16'h05E0,    1,    0,     0,  -1,    1,  1,  -1,    0,   0};
    vecs[4] = '{16'h0040,   30, 8'h20,   26,   5,   31,  1,  -1,   26,   0};
    vecs[5] = '{16'h0800,   20,    0,    16,   5,   21,  1,  -1,   16,   1};
    vecs[6] = '{16'h0600,   50,    0,    46,   5,   51,  0,  -1,   46,   1};
    vecs[7] = '{16'h05DC, 1504,    0,  1500,   5, 1504,  0, 1504, 1500,  0};
    vecs[8] = '{16'h05DD,    1,    0,     0,  -1,    1,  1,  -1,    0,   0};
    vecs[9] = '{16'h86DD, 1520,    0,  1500,   5, 1505,  1,  -1, 1500,   1};

    reset  = 1'b1;
    enable = 1'b0;
    data   = 8'h00;
    start  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    repeat (2) step(1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 10; i++) begin
      run_frame(vecs[i], i);
      repeat (3) step(1'b0, 8'h00, 1'b0);
    end

    // A start on the frame_done cycle must be ignored; if taken, TL=0x4243 would open a runt STREAM frame.
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h40, 1'b0);
    for (int k = 0; k < 68; k++) step(1'b1, 8'(k), k == 0);
    step(1'b1, 8'h55, 1'b1);
    chk("same_cyc_done", int'(frame_done), 1);
    dn = 0;
    pv = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 8'h00, 1'b0);
      if (frame_done) dn++;
      if (payload_valid) pv++;
    end
    chk("same_cyc_no_done", dn, 0);
    chk("same_cyc_no_valid", pv, 0);
    chk("same_cyc_etype", int'(ethertype_mode), 0);
    repeat (2) step(1'b0, 8'h00, 1'b0);

    // Reset in the middle of a LEN frame clears outputs without waiting for a clock edge.
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h40, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b1, 8'(k + 1), k == 0);
    chk("mid_valid_before", int'(payload_valid), 1);
    chk("mid_bc_before", int'(byte_count), 7);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    repeat (2) step(1'b0, 8'h00, 1'b0);
    run_frame(vecs[0], 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
